reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter N, default 16: data width in bits.
REQ-002 Parameter DEPTH, default 8: number of registers; power of two, at least 2.
REQ-003 Parameter NRD, default 2: number of read ports, at least 1.
REQ-004 Parameter R0_ZERO, default 0: when 1, register 0 is hardwired to zero.
REQ-005 Derived localparam AW = clog2(DEPTH): address width.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 we0  in  1  write enable, port 0.
REQ-009 waddr0  in  AW  write address, port 0.
REQ-010 wdata0  in  N  write data, port 0.
REQ-011 we1 / waddr1 / wdata1  in  1 / AW / N  write port 1, same meaning as port 0.
REQ-012 raddr  in  NRD*AW  packed read addresses; port p occupies bits [p*AW +: AW].
REQ-013 rdata  out  NRD*N  packed read data; port p occupies bits [p*N +: N].
REQ-014 busy_set  in  1  marks register busy_addr as pending a write (outstanding producer).
REQ-015 busy_addr  in  AW  register to mark busy.
REQ-016 flush  in  1  clears all pending marks.
REQ-017 hazard  out  NRD  per-read-port flag: the operand is not yet valid.
REQ-018 busy_vec  out  DEPTH  registered pending bit for each register.

Function
REQ-019 Writes are captured on the rising clk edge when the port enable is high.
REQ-020 When we0 and we1 target the same address in one cycle, port 1 wins.
REQ-021 Reads are combinational with zero latency.
REQ-022 Read bypass priority: port-1 write data if we1 and waddr1 match; else port-0 write data if we0 and waddr0 match; else array contents.
REQ-023 With R0_ZERO=1: reads of address 0 return 0, writes to address 0 are dropped, and busy_set on address 0 is ignored.
REQ-024 Busy update on the rising edge: a write on either port clears busy[waddr]; busy_set sets busy[busy_addr].
REQ-025 busy_set and a write to the same address in the same cycle leave the bit set (set wins).
REQ-026 flush clears every busy bit and overrides a same-cycle busy_set.
REQ-027 flush does not affect register contents or writes in the same cycle.
REQ-028 hazard[p] = busy[raddr_p] AND no same-cycle write to raddr_p on either port AND NOT (R0_ZERO AND raddr_p == 0).
REQ-029 busy_vec reflects the busy register state directly, with no combinational path from inputs.
REQ-030 Addresses are always in range, so no out-of-range handling is needed.

Reset
REQ-031 While rst is high, all registers and all busy bits are 0 immediately, independent of clk.
REQ-032 While in reset: rdata shows the bypassed write data if a write enable is high, else 0; hazard is 0; busy_vec is 0; writes are ignored.
REQ-033 When reset deasserts mid-operation, the first rising edge after deassertion behaves normally; no state is retained from before reset.

Structure
REQ-034 Package regfile_pkg holds the default N/DEPTH/NRD values and the helper function for AW.
REQ-035 A sub-module reg_busy_sb holds the busy bit vector and the hazard logic; the data array, write logic and bypass logic stay in reg_file_sb.
REQ-036 Read ports are produced with a generate loop over NRD; no per-port copies are written by hand.

Verification
REQ-037 Reset, then write 0x1234 to r3 on port 0, then read raddr p0=3 -> rdata p0 = 0x1234 on the next cycle; during the write cycle the bypass returns 0x1234.
REQ-038 Same cycle: we0 writes r5=0xAAAA and we1 writes r5=0x5555 -> r5 = 0x5555; a bypass read in that cycle returns 0x5555.
REQ-039 busy_set r2; next cycle read p1=2 -> hazard[1]=1; we0 writes r2=0x0F0F -> hazard[1]=0 in that cycle and rdata = 0x0F0F; busy_vec[2]=0 afterwards.
REQ-040 busy_set r4 together with we1 to r4 -> busy_vec[4]=1 after the edge; busy_set r6 together with flush -> busy_vec = 0.
REQ-041 R0_ZERO=1: write 0xFFFF to r0 and busy_set r0 -> read r0 returns 0, hazard=0, busy_vec[0]=0.
REQ-042 Assert rst asynchronously between edges with r1=0x00FF and busy r1 set -> rdata=0 and busy_vec=0 immediately; normal operation on the first edge after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helper for the scoreboarded register file.
package regfile_pkg;

   localparam int RF_N     = 16;
   localparam int RF_DEPTH = 8;
   localparam int RF_NRD   = 2;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/reg_busy_sb.sv
// Pending-write scoreboard: one busy bit per register plus per-read-port hazard flags.
module reg_busy_sb
   import regfile_pkg::*;
#(
   parameter  int DEPTH   = RF_DEPTH,
   parameter  int NRD     = RF_NRD,
   parameter  int R0_ZERO = 0,
   localparam int AW      = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we0,
   input  logic [AW-1:0]     waddr0,
   input  logic              we1,
   input  logic [AW-1:0]     waddr1,
   input  logic              busy_set,
   input  logic [AW-1:0]     busy_addr,
   input  logic              flush,
   input  logic [NRD*AW-1:0] raddr,
   output logic [NRD-1:0]    hazard,
   output logic [DEPTH-1:0]  busy_vec
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Order matters: write clears, then set overrides clear, then flush overrides all.
   always_comb begin
      busy_d = busy_q;
      if (we0) busy_d[waddr0] = 1'b0;
      if (we1) busy_d[waddr1] = 1'b0;
      if (busy_set && !((R0_ZERO != 0) && (busy_addr == '0))) busy_d[busy_addr] = 1'b1;
      if (flush) busy_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy_vec = busy_q;

   for (genvar p = 0; p < NRD; p++) begin : g_haz
      logic [AW-1:0] ra;
      assign ra = raddr[p*AW +: AW];
      // A same-cycle write resolves the operand through the bypass.
      assign hazard[p] = busy_q[ra]
                       && !(we0 && (waddr0 == ra))
                       && !(we1 && (waddr1 == ra))
                       && !((R0_ZERO != 0) && (ra == '0));
   end

endmodule

// File: rtl/reg_file_sb.sv
// Two-write, NRD-read register file with write-to-read bypass and a busy scoreboard.
module reg_file_sb
   import regfile_pkg::*;
#(
   parameter  int N       = RF_N,
   parameter  int DEPTH   = RF_DEPTH,
   parameter  int NRD     = RF_NRD,
   parameter  int R0_ZERO = 0,
   localparam int AW      = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we0,
   input  logic [AW-1:0]     waddr0,
   input  logic [N-1:0]      wdata0,
   input  logic              we1,
   input  logic [AW-1:0]     waddr1,
   input  logic [N-1:0]      wdata1,
   input  logic [NRD*AW-1:0] raddr,
   output logic [NRD*N-1:0]  rdata,
   input  logic              busy_set,
   input  logic [AW-1:0]     busy_addr,
   input  logic              flush,
   output logic [NRD-1:0]    hazard,
   output logic [DEPTH-1:0]  busy_vec
);

   logic [N-1:0] mem [DEPTH];

   // Port 1 is written last so it wins a same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (we0 && !((R0_ZERO != 0) && (waddr0 == '0))) mem[waddr0] <= wdata0;
         if (we1 && !((R0_ZERO != 0) && (waddr1 == '0))) mem[waddr1] <= wdata1;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0] ra;
      logic [N-1:0]  rd;
      assign ra = raddr[p*AW +: AW];
      always_comb begin
         rd = mem[ra];
         if (we0 && (waddr0 == ra)) rd = wdata0;
         if (we1 && (waddr1 == ra)) rd = wdata1;
         if ((R0_ZERO != 0) && (ra == '0)) rd = '0;
      end
      assign rdata[p*N +: N] = rd;
   end

   reg_busy_sb #(
      .DEPTH   (DEPTH),
      .NRD     (NRD),
      .R0_ZERO (R0_ZERO)
   ) u_busy (
      .clk       (clk),
      .rst       (rst),
      .we0       (we0),
      .waddr0    (waddr0),
      .we1       (we1),
      .waddr1    (waddr1),
      .busy_set  (busy_set),
      .busy_addr (busy_addr),
      .flush     (flush),
      .raddr     (raddr),
      .hazard    (hazard),
      .busy_vec  (busy_vec)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed bench for reg_file_sb, both with and without a hardwired r0.
module tb_reg_file_sb;

   logic        clk;
   logic        rst;
   logic        we0, we1;
   logic [2:0]  waddr0, waddr1;
   logic [15:0] wdata0, wdata1;
   logic [5:0]  raddr;
   logic        busy_set;
   logic [2:0]  busy_addr;
   logic        flush;
   logic [31:0] rdata_a, rdata_b;
   logic [1:0]  hazard_a, hazard_b;
   logic [7:0]  busy_vec_a, busy_vec_b;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state, index 0 = plain DUT, index 1 = R0_ZERO DUT.
   logic [15:0] m_reg  [2][8];
   logic        m_busy [2][8];

   reg_file_sb #(.N(16), .DEPTH(8), .NRD(2), .R0_ZERO(0)) dut_a (
      .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rdata_a),
      .busy_set(busy_set), .busy_addr(busy_addr), .flush(flush),
      .hazard(hazard_a), .busy_vec(busy_vec_a));

   reg_file_sb #(.N(16), .DEPTH(8), .NRD(2), .R0_ZERO(1)) dut_b (
      .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rdata_b),
      .busy_set(busy_set), .busy_addr(busy_addr), .flush(flush),
      .hazard(hazard_b), .busy_vec(busy_vec_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_rd(input int v, input logic [2:0] ra);
      if (v == 1 && ra == 3'd0) return 16'h0;
      if (we1 && waddr1 == ra) return wdata1;
      if (we0 && waddr0 == ra) return wdata0;
      return m_reg[v][ra];
   endfunction

   function automatic logic model_hz(input int v, input logic [2:0] ra);
      if (v == 1 && ra == 3'd0) return 1'b0;
      return m_busy[v][ra] && !(we0 && waddr0 == ra) && !(we1 && waddr1 == ra);
   endfunction

   task automatic model_reset();
      for (int v = 0; v < 2; v++)
         for (int i = 0; i < 8; i++) begin
            m_reg[v][i]  = 16'h0;
            m_busy[v][i] = 1'b0;
         end
   endtask

   task automatic model_edge();
      bit z;
      for (int v = 0; v < 2; v++) begin
         z = (v == 1);
         if (we0 && !(z && waddr0 == 3'd0)) m_reg[v][waddr0] = wdata0;
         if (we1 && !(z && waddr1 == 3'd0)) m_reg[v][waddr1] = wdata1;
         if (we0) m_busy[v][waddr0] = 1'b0;
         if (we1) m_busy[v][waddr1] = 1'b0;
         if (busy_set && !(z && busy_addr == 3'd0)) m_busy[v][busy_addr] = 1'b1;
         if (flush)
            for (int i = 0; i < 8; i++) m_busy[v][i] = 1'b0;
      end
   endtask

   task automatic check_all();
      logic [2:0]  ra;
      logic [7:0]  bv;
      logic [15:0] got_rd;
      logic        got_hz;
      for (int v = 0; v < 2; v++) begin
         for (int p = 0; p < 2; p++) begin
            ra     = raddr[p*3 +: 3];
            got_rd = (v == 1) ? rdata_b[p*16 +: 16] : rdata_a[p*16 +: 16];
            got_hz = (v == 1) ? hazard_b[p] : hazard_a[p];
            check($sformatf("rdata%0d_z%0d", p, v), 64'(got_rd), 64'(model_rd(v, ra)));
            check($sformatf("hazard%0d_z%0d", p, v), 64'(got_hz), 64'(model_hz(v, ra)));
         end
         for (int i = 0; i < 8; i++) bv[i] = m_busy[v][i];
         check($sformatf("busy_vec_z%0d", v), 64'((v == 1) ? busy_vec_b : busy_vec_a), 64'(bv));
      end
   endtask

   // Called shortly after a falling edge with inputs already driven.
   task automatic step();
      if (rst) model_reset();
      #1 check_all();
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
      raddr = 0; busy_set = 0; busy_addr = 0; flush = 0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      model_reset();
      @(negedge clk);
      #1 check("reset_busy_vec", 64'(busy_vec_a), 64'h0);
      check("reset_rdata", 64'(rdata_a), 64'h0);
      step();
      rst = 1'b0;

      // Write r3 and observe bypass then stored value.
      we0 = 1; waddr0 = 3; wdata0 = 16'h1234; raddr = 6'd3;
      #1 check("bypass_r3", 64'(rdata_a[15:0]), 64'h1234);
      step();
      idle(); raddr = 6'd3;
      #1 check("read_r3", 64'(rdata_a[15:0]), 64'h1234);
      step();

      // Dual write collision.
      we0 = 1; waddr0 = 5; wdata0 = 16'hAAAA; we1 = 1; waddr1 = 5; wdata1 = 16'h5555; raddr = 6'd5;
      #1 check("bypass_r5", 64'(rdata_a[15:0]), 64'h5555);
      step();
      idle(); raddr = 6'd5;
      #1 check("read_r5", 64'(rdata_a[15:0]), 64'h5555);
      step();

      // Hazard raised then resolved by a same-cycle write.
      idle(); busy_set = 1; busy_addr = 2;
      step();
      idle(); raddr = {3'd2, 3'd0};
      #1 check("hazard_r2", 64'(hazard_a[1]), 64'h1);
      step();
      we0 = 1; waddr0 = 2; wdata0 = 16'h0F0F;
      #1 check("hazard_r2_wr", 64'(hazard_a[1]), 64'h0);
      check("bypass_r2", 64'(rdata_a[31:16]), 64'h0F0F);
      step();
      idle();
      #1 check("busy_r2_clr", 64'(busy_vec_a[2]), 64'h0);
      step();

      // Set beats write; flush beats set.
      busy_set = 1; busy_addr = 4; we1 = 1; waddr1 = 4; wdata1 = 16'h4444;
      step();
      idle();
      #1 check("busy_r4_set", 64'(busy_vec_a[4]), 64'h1);
      busy_set = 1; busy_addr = 6; flush = 1;
      step();
      idle();
      #1 check("flush_a", 64'(busy_vec_a), 64'h0);
      check("flush_b", 64'(busy_vec_b), 64'h0);
      step();

      // Hardwired r0.
      we0 = 1; waddr0 = 0; wdata0 = 16'hFFFF; busy_set = 1; busy_addr = 0;
      step();
      idle(); raddr = 6'd0;
      #1 check("r0_rdata", 64'(rdata_b), 64'h0);
      check("r0_hazard", 64'(hazard_b), 64'h0);
      check("r0_busy", 64'(busy_vec_b[0]), 64'h0);
      step();

      // Asynchronous reset between edges.
      we0 = 1; waddr0 = 1; wdata0 = 16'h00FF; busy_set = 1; busy_addr = 1;
      step();
      idle(); raddr = 6'd1;
      #1 check("pre_rst_r1", 64'(rdata_a[15:0]), 64'h00FF);
      check("pre_rst_busy", 64'(busy_vec_a[1]), 64'h1);
      rst = 1'b1;
      #1 model_reset();
      check("async_rst_rd", 64'(rdata_a[15:0]), 64'h0);
      check("async_rst_busy", 64'(busy_vec_a), 64'h0);
      check_all();
      #1 rst = 1'b0;
      we1 = 1; waddr1 = 1; wdata1 = 16'hBEEF;
      step();
      idle(); raddr = 6'd1;
      #1 check("post_rst_r1", 64'(rdata_a[15:0]), 64'hBEEF);
      step();

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         we0       = 1'($urandom);
         we1       = 1'($urandom);
         waddr0    = 3'($urandom);
         waddr1    = ($urandom_range(0, 3) == 0) ? waddr0 : 3'($urandom);
         wdata0    = 16'($urandom);
         wdata1    = 16'($urandom);
         raddr     = 6'($urandom);
         busy_set  = 1'($urandom);
         busy_addr = 3'($urandom);
         flush     = ($urandom_range(0, 7) == 0);
         rst       = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
